psimd_fflags_ctrl: RTL
======================

// Module: psimd_fflags_ctrl
// PURPOSE
// Sticky floating-point exception-flag controller for the 4-lane PSIMD DLFloat datapath. Takes the
//   per-lane flag vectors from the exception collection stage, qualifies them by valid and lane mask,
//   and accumulates them into a sticky fflags register (RISC-V order NV,DZ,OF,UF,NX = [4:0]).
// Raises a trap request for enabled flags, stalls the datapath until the request is acknowledged,
//   and exposes CSR read/write/set/clear access plus per-flag saturating event counters.
// PARAMETERS
// LANES   4  number of SIMD lanes (width of every per-lane flag bus)
// CNT_W   8  width of each per-flag saturating event counter
// PORTS
// clk          in   1        clock; all state changes on rising edge
// rst          in   1        synchronous reset, active-high
// res_valid    in   1        datapath result valid this cycle; flags are sampled only when res_valid&res_ready
// res_ready    out  1        controller can accept a result (low while a trap is pending)
// lane_mask    in   LANES    1 = lane active for this result; inactive lanes' flags ignored
// invalid      in   LANES    per-lane invalid-operation flag
// div_by_zero  in   LANES    per-lane divide-by-zero flag
// overflow     in   LANES    per-lane overflow flag
// underflow    in   LANES    per-lane underflow flag
// inexact      in   LANES    per-lane inexact flag
// csr_op       in   2        00 none, 01 write, 10 set (OR), 11 clear (AND-NOT), applied to fflags
// csr_wdata    in   5        CSR operand
// trap_en      in   5        per-flag trap enable, same bit order as fflags
// fflags       out  5        sticky accumulated flags
// trap_req     out  1        trap request, level, held until trap_ack
// trap_cause   out  5        enabled flags newly raised by the trapping result (held while trap_req)
// trap_lanes   out  LANES    lanes that raised any enabled flag in the trapping result
// trap_ack     in   1        trap handler acknowledge
// cnt_nv,cnt_dz,cnt_of,cnt_uf,cnt_nx  out  CNT_W  number of accepted results raising that flag (any lane)
// cnt_clr      in   1        synchronous clear of all five counters
// BEHAVIOUR
// Reset: fflags=0, all counters=0, trap_req=0, trap_cause=0, trap_lanes=0, state=IDLE, res_ready=1.
// acc = res_valid & res_ready. per-flag raw[k] = |(flag_bus_k & lane_mask) when acc, else 0.
// fflags next = csr_result(fflags) | raw: CSR op applied first, then new raw flags ORed in; a CSR
//   clear/write in the same cycle as an exception never loses the new flag. Visible next cycle.
// new_trap = |(raw & trap_en & ~fflags) : only flags not already sticky cause a trap (fflags = pre-update value).
// Counter k increments by 1 when raw[k]=1; saturates at all-ones; cnt_clr has priority over increment.
// FSM: IDLE -> TRAP when new_trap (result is still accepted/accumulated that cycle); capture
//   trap_cause = raw & trap_en & ~fflags, trap_lanes = OR over enabled flags of (bus & lane_mask).
// TRAP: trap_req=1, res_ready=0, cause/lanes held stable; CSR ops still honoured; on trap_ack -> RECOVER.
// RECOVER: one cycle, trap_req=0, res_ready=0 (handler reads fflags); -> IDLE. trap_cause/lanes retain.
// trap_ack in IDLE or RECOVER is ignored. trap_en changes take effect on the next accepted result only.
// lane_mask=0 or res_valid=0: no flag, counter or FSM effect. rst in any state -> IDLE next cycle.
// Latency: flag in -> fflags/trap_req out = 1 cycle; trap_ack -> res_ready high = 2 cycles.
// TESTING
// Reset, then res_valid=1, overflow=4'b0100, lane_mask=4'b1111, trap_en=0 -> fflags=5'b00100 next cycle, cnt_of=1, trap_req=0.
// trap_en=5'b10000, invalid=4'b0010, mask=4'b1111 -> trap_req=1, trap_cause=10000, trap_lanes=0010, res_ready=0 until ack+2.
// invalid=4'b1000, lane_mask=4'b0111 -> no flag, no counter change, no trap.
// fflags=00001, csr_op=11 csr_wdata=00001 same cycle as inexact on lane0 -> fflags stays 00001.
// 256 results with underflow on one lane, CNT_W=8 -> cnt_uf saturates at 255; cnt_clr -> 0.
// NV already sticky, trap_en NV=1, invalid again -> no trap; assert rst while in TRAP -> all outputs reset values.

Source files
------------

// File: rtl/psimd_fflags_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : psimd_fflags_ctrl
// Description : Sticky floating-point exception-flag controller for the
//               4-lane PSIMD DLFloat datapath. Qualifies per-lane flags by
//               valid/ready and lane mask, accumulates them into a sticky
//               fflags register (NV,DZ,OF,UF,NX = [4:0]), raises a level
//               trap request for newly raised enabled flags, stalls the
//               datapath until the trap is acknowledged, and provides CSR
//               write/set/clear access plus per-flag saturating counters.
// Ports       : clk, rst (sync, active-high)
//               res_valid/res_ready     - result handshake
//               lane_mask + 5 flag buses - per-lane exception flags
//               csr_op/csr_wdata        - CSR access to fflags
//               trap_en                 - per-flag trap enable
//               fflags                  - sticky flags
//               trap_req/trap_cause/trap_lanes/trap_ack - trap interface
//               cnt_nv..cnt_nx/cnt_clr  - per-flag event counters
// Revision    : 1.0 - initial release
// ============================================================================
module psimd_fflags_ctrl #(
    parameter int LANES = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             res_valid,
    output logic             res_ready,
    input  logic [LANES-1:0] lane_mask,
    input  logic [LANES-1:0] invalid,
    input  logic [LANES-1:0] div_by_zero,
    input  logic [LANES-1:0] overflow,
    input  logic [LANES-1:0] underflow,
    input  logic [LANES-1:0] inexact,
    input  logic [1:0]       csr_op,
    input  logic [4:0]       csr_wdata,
    input  logic [4:0]       trap_en,
    output logic [4:0]       fflags,
    output logic             trap_req,
    output logic [4:0]       trap_cause,
    output logic [LANES-1:0] trap_lanes,
    input  logic             trap_ack,
    output logic [CNT_W-1:0] cnt_nv,
    output logic [CNT_W-1:0] cnt_dz,
    output logic [CNT_W-1:0] cnt_of,
    output logic [CNT_W-1:0] cnt_uf,
    output logic [CNT_W-1:0] cnt_nx,
    input  logic             cnt_clr
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_TRAP    = 2'd1;
    localparam logic [1:0] S_RECOVER = 2'd2;

    localparam logic [1:0] c_CSR_NONE  = 2'b00;
    localparam logic [1:0] c_CSR_WRITE = 2'b01;
    localparam logic [1:0] c_CSR_SET   = 2'b10;

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [4:0]       r_fflags;
    logic [4:0]       r_trap_cause;
    logic [LANES-1:0] r_trap_lanes;

    logic             w_acc;
    logic [LANES-1:0] w_bus [5];
    logic [4:0]       w_raw;
    logic [4:0]       w_csr_res;
    logic [4:0]       w_trap_bits;
    logic             w_new_trap;
    logic [LANES-1:0] w_lane_hit;

    // Results are only accepted while idle; a pending or recovering trap
    // back-pressures the datapath.
    assign res_ready = (r_state == S_IDLE);
    assign w_acc     = res_valid & res_ready;

    // Bus index matches the fflags bit position.
    assign w_bus[4] = invalid     & lane_mask;
    assign w_bus[3] = div_by_zero & lane_mask;
    assign w_bus[2] = overflow    & lane_mask;
    assign w_bus[1] = underflow   & lane_mask;
    assign w_bus[0] = inexact     & lane_mask;

    for (genvar k = 0; k < 5; k++) begin : g_raw
        assign w_raw[k] = w_acc & (|w_bus[k]);
    end

    always_comb begin
        w_csr_res = r_fflags;
        case (csr_op)
            c_CSR_NONE:  w_csr_res = r_fflags;
            c_CSR_WRITE: w_csr_res = csr_wdata;
            c_CSR_SET:   w_csr_res = r_fflags | csr_wdata;
            default:     w_csr_res = r_fflags & ~csr_wdata;
        endcase
    end

    // Only flags that are not already sticky may start a trap.
    assign w_trap_bits = w_raw & trap_en & ~r_fflags;
    assign w_new_trap  = |w_trap_bits;

    // Lanes contributing to any trap-enabled flag of this result.
    always_comb begin
        w_lane_hit = '0;
        for (int k = 0; k < 5; k++) begin
            if (trap_en[k]) begin
                w_lane_hit = w_lane_hit | w_bus[k];
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:    if (w_new_trap) w_state_nxt = S_TRAP;
            S_TRAP:    if (trap_ack)   w_state_nxt = S_RECOVER;
            S_RECOVER: w_state_nxt = S_IDLE;
            default:   w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_fflags     <= '0;
            r_trap_cause <= '0;
            r_trap_lanes <= '0;
        end else begin
            r_state  <= w_state_nxt;
            // CSR result first, then new flags ORed on top so an exception
            // is never lost to a simultaneous clear or write.
            r_fflags <= w_csr_res | w_raw;
            if ((r_state == S_IDLE) && w_new_trap) begin
                r_trap_cause <= w_trap_bits;
                r_trap_lanes <= w_lane_hit;
            end
        end
    end

    for (genvar k = 0; k < 5; k++) begin : g_cnt
        logic [CNT_W-1:0] r_cnt;
        always_ff @(posedge clk) begin
            if (rst || cnt_clr) begin
                r_cnt <= '0;
            end else if (w_raw[k] && (r_cnt != {CNT_W{1'b1}})) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign cnt_nv = g_cnt[4].r_cnt;
    assign cnt_dz = g_cnt[3].r_cnt;
    assign cnt_of = g_cnt[2].r_cnt;
    assign cnt_uf = g_cnt[1].r_cnt;
    assign cnt_nx = g_cnt[0].r_cnt;

    assign fflags     = r_fflags;
    assign trap_req   = (r_state == S_TRAP);
    assign trap_cause = r_trap_cause;
    assign trap_lanes = r_trap_lanes;

endmodule
`default_nettype wire
